// File: rtl/hazard_response_unit_if.sv
// Bundle of the hazard-response signals exchanged between the pipeline
// (master side) and hazard_response_unit (slave side).
//   ID-stage inputs : id_ctrl, id_rs/rt/rd, id_rs_data, id_rt_data, id_jump
//   Hazard inputs   : ex_branch_taken, stall, forward_a, forward_b
//   Bypass data     : mem_alu_result, wb_write_data
//   Pipe controls   : pc_write, ifid_write, ifid_flush
//   EX-stage outputs: ex_ctrl, ex_rs/rt/rd, ex_op_a, ex_op_b
//   Debug counters  : stall_count, flush_count
interface hazard_response_unit_if #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
);
    logic [CTRL_W-1:0] id_ctrl;
    logic [4:0]        id_rs;
    logic [4:0]        id_rt;
    logic [4:0]        id_rd;
    logic [DATA_W-1:0] id_rs_data;
    logic [DATA_W-1:0] id_rt_data;
    logic              id_jump;
    logic              ex_branch_taken;
    logic              stall;
    logic [1:0]        forward_a;
    logic [1:0]        forward_b;
    logic [DATA_W-1:0] mem_alu_result;
    logic [DATA_W-1:0] wb_write_data;

    logic              pc_write;
    logic              ifid_write;
    logic              ifid_flush;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [4:0]        ex_rs;
    logic [4:0]        ex_rt;
    logic [4:0]        ex_rd;
    logic [DATA_W-1:0] ex_op_a;
    logic [DATA_W-1:0] ex_op_b;
    logic [CNT_W-1:0]  stall_count;
    logic [CNT_W-1:0]  flush_count;

    modport slave (
        input  id_ctrl, id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_jump,
               ex_branch_taken, stall, forward_a, forward_b,
               mem_alu_result, wb_write_data,
        output pc_write, ifid_write, ifid_flush, ex_ctrl, ex_rs, ex_rt, ex_rd,
               ex_op_a, ex_op_b, stall_count, flush_count
    );

    modport master (
        output id_ctrl, id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_jump,
               ex_branch_taken, stall, forward_a, forward_b,
               mem_alu_result, wb_write_data,
        input  pc_write, ifid_write, ifid_flush, ex_ctrl, ex_rs, ex_rt, ex_rd,
               ex_op_a, ex_op_b, stall_count, flush_count
    );
endinterface

// File: rtl/hazard_response_unit.sv
// Applies hazard-unit decisions to the 5-stage pipeline: load-use stalls,
// branch/jump flushes and EX operand forwarding. Owns the ID/EX register and
// keeps saturating stall/flush event counters.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-high reset
//   bus   - hazard_response_unit_if.slave (see interface file for signals)
//
// state  | meaning
// -------+-----------------------------------------------------------
// RUN    | normal operation, a stall request is accepted
// BUBBLE | EX holds the load-use bubble; stall is ignored this cycle
module hazard_response_unit #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    hazard_response_unit_if.slave   bus
);

    typedef enum logic {
        S_RUN    = 1'b0,
        S_BUBBLE = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic              w_pc_write;
    logic              w_ifid_write;
    logic              w_ifid_flush;
    logic              w_bubble;
    logic              w_stall_acc;

    logic [CTRL_W-1:0] r_ex_ctrl;
    logic [4:0]        r_ex_rs;
    logic [4:0]        r_ex_rt;
    logic [4:0]        r_ex_rd;
    logic [DATA_W-1:0] r_ex_rs_data;
    logic [DATA_W-1:0] r_ex_rt_data;
    logic [CNT_W-1:0]  r_stall_count;
    logic [CNT_W-1:0]  r_flush_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Priority: branch > stall > jump > normal. BUBBLE always returns to
    // RUN, so one load-use hazard costs exactly one cycle.
    always_comb begin
        w_state_nxt  = S_RUN;
        w_pc_write   = 1'b1;
        w_ifid_write = 1'b1;
        w_ifid_flush = 1'b0;
        w_bubble     = 1'b0;
        w_stall_acc  = 1'b0;
        if (bus.ex_branch_taken) begin
            w_ifid_flush = 1'b1;
            w_bubble     = 1'b1;
        end else if (bus.stall && (r_state == S_RUN)) begin
            w_pc_write   = 1'b0;
            w_ifid_write = 1'b0;
            w_bubble     = 1'b1;
            w_stall_acc  = 1'b1;
            w_state_nxt  = S_BUBBLE;
        end else if (bus.id_jump) begin
            w_ifid_flush = 1'b1;
        end
    end

    // Reset overrides the pipe controls immediately, not on the next edge.
    assign bus.pc_write   = w_pc_write & ~reset;
    assign bus.ifid_write = w_ifid_write & ~reset;
    assign bus.ifid_flush = w_ifid_flush | reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ex_ctrl    <= '0;
            r_ex_rs      <= '0;
            r_ex_rt      <= '0;
            r_ex_rd      <= '0;
            r_ex_rs_data <= '0;
            r_ex_rt_data <= '0;
        end else if (w_bubble) begin
            r_ex_ctrl    <= '0;
            r_ex_rs      <= '0;
            r_ex_rt      <= '0;
            r_ex_rd      <= '0;
            r_ex_rs_data <= '0;
            r_ex_rt_data <= '0;
        end else begin
            r_ex_ctrl    <= bus.id_ctrl;
            r_ex_rs      <= bus.id_rs;
            r_ex_rt      <= bus.id_rt;
            r_ex_rd      <= bus.id_rd;
            r_ex_rs_data <= bus.id_rs_data;
            r_ex_rt_data <= bus.id_rt_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else begin
            if (w_stall_acc && (r_stall_count != {CNT_W{1'b1}})) begin
                r_stall_count <= r_stall_count + 1'b1;
            end
            if (w_ifid_flush && (r_flush_count != {CNT_W{1'b1}})) begin
                r_flush_count <= r_flush_count + 1'b1;
            end
        end
    end

    // Select 2'b11 is not a legal hazard-unit output; it falls back to
    // the register-file value.
    always_comb begin
        case (bus.forward_a)
            2'b10:   bus.ex_op_a = bus.mem_alu_result;
            2'b01:   bus.ex_op_a = bus.wb_write_data;
            default: bus.ex_op_a = r_ex_rs_data;
        endcase
    end

    always_comb begin
        case (bus.forward_b)
            2'b10:   bus.ex_op_b = bus.mem_alu_result;
            2'b01:   bus.ex_op_b = bus.wb_write_data;
            default: bus.ex_op_b = r_ex_rt_data;
        endcase
    end

    assign bus.ex_ctrl     = r_ex_ctrl;
    assign bus.ex_rs       = r_ex_rs;
    assign bus.ex_rt       = r_ex_rt;
    assign bus.ex_rd       = r_ex_rd;
    assign bus.stall_count = r_stall_count;
    assign bus.flush_count = r_flush_count;

endmodule
